// File: rtl/buff_uart_tx_arbiter.sv
// Purpose : round-robin arbiter that hands the UART transmit FIFO to one requester for a whole burst.
// Latency : req in IDLE -> grant and first write the next cycle; two dead cycles (RELEASE, IDLE) between bursts.
// Backpr. : tx_fifo_not_full low stalls the burst in place (no write, no ack, grant held, no timeout).
//
// Ports:
//   clock, resetn          - single clock, synchronous active-low reset
//   req, burst_len         - per-requester level request and word count (slice i at i*len_width)
//   req_data               - per-requester current word (slice i at i*width)
//   grant, word_ack        - one-hot ownership / per-word accept pulse (next word due next cycle)
//   uart_address, uart_write_enable, uart_data, tx_fifo_not_full - UART transmit FIFO side
//   busy, bursts_done      - not-IDLE flag and wrapping count of completed bursts
module buff_uart_tx_arbiter #(
  parameter int width          = 8,
  parameter int address_width  = 4,
  parameter int tx_address     = 1,
  parameter int num_requesters = 4,
  parameter int len_width      = 4
) (
  input  logic                                clock,
  input  logic                                resetn,
  input  logic [num_requesters-1:0]           req,
  input  logic [num_requesters*len_width-1:0] burst_len,
  input  logic [num_requesters*width-1:0]     req_data,
  output logic [num_requesters-1:0]           grant,
  output logic [num_requesters-1:0]           word_ack,
  output logic [address_width-1:0]            uart_address,
  output logic                                uart_write_enable,
  output logic [width-1:0]                    uart_data,
  input  logic                                tx_fifo_not_full,
  output logic                                busy,
  output logic [15:0]                         bursts_done
);

  localparam int iw = (num_requesters > 1) ? $clog2(num_requesters) : 1;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SEND    = 2'd1;
  localparam logic [1:0] RELEASE = 2'd2;

  logic [1:0]           state;
  logic [iw-1:0]        grant_idx;
  logic [iw-1:0]        ptr;
  logic [len_width-1:0] remaining;

  logic [len_width-1:0] len_arr  [num_requesters];
  logic [width-1:0]     data_arr [num_requesters];
  logic [num_requesters-1:0] elig;

  logic          pick_vld;
  logic [iw-1:0] pick_idx;
  logic [iw-1:0] cand;
  int            pick_j;
  logic          in_send;

  for (genvar i = 0; i < num_requesters; i++) begin : g_slice
    assign len_arr[i]  = burst_len[i*len_width +: len_width];
    assign data_arr[i] = req_data[i*width +: width];
    // A zero-length request would never complete, so it is simply not a candidate.
    assign elig[i]     = req[i] && (len_arr[i] != '0);
  end

  // Scan from the priority pointer upward with wrap. Iterating from the far end
  // downward lets the closest eligible index overwrite the others.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    pick_j   = 0;
    cand     = '0;
    for (int k = num_requesters - 1; k >= 0; k--) begin
      pick_j = int'(ptr) + k;
      if (pick_j >= num_requesters) pick_j = pick_j - num_requesters;
      cand = iw'(pick_j);
      if (elig[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  assign in_send = (state == SEND);

  // Dropping req mid-burst suppresses the write in that same cycle (abort).
  assign uart_write_enable = in_send && tx_fifo_not_full && req[grant_idx];
  assign uart_data         = in_send ? data_arr[grant_idx] : '0;
  assign word_ack          = uart_write_enable ? grant : '0;
  assign uart_address      = in_send ? address_width'(tx_address) : '0;
  assign busy              = (state != IDLE);

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state       <= IDLE;
      grant       <= '0;
      grant_idx   <= '0;
      remaining   <= '0;
      ptr         <= '0;
      bursts_done <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_vld) begin
            state     <= SEND;
            grant     <= num_requesters'(1) << pick_idx;
            grant_idx <= pick_idx;
            // Length is captured here; later changes to burst_len are ignored.
            remaining <= len_arr[pick_idx];
          end
        end
        SEND: begin
          if (!req[grant_idx]) begin
            state <= RELEASE;
            grant <= '0;
          end else if (uart_write_enable) begin
            remaining <= remaining - 1'b1;
            if (remaining == len_width'(1)) begin
              bursts_done <= bursts_done + 16'd1;
              state       <= RELEASE;
              grant       <= '0;
            end
          end
        end
        RELEASE: begin
          state <= IDLE;
          ptr   <= (grant_idx == iw'(num_requesters - 1)) ? '0 : grant_idx + iw'(1);
        end
        default: begin
          state <= IDLE;
          grant <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_buff_uart_tx_arbiter.sv
// Directed bench for buff_uart_tx_arbiter: reset, single burst, round-robin,
// backpressure, abort, zero-length filtering and mid-burst reset.
module tb_buff_uart_tx_arbiter;

  logic        clock = 1'b0;
  logic        resetn;
  logic [3:0]  req;
  logic [15:0] burst_len;
  logic [31:0] req_data;
  logic        tx_fifo_not_full;
  logic [3:0]  grant;
  logic [3:0]  word_ack;
  logic [3:0]  uart_address;
  logic        uart_write_enable;
  logic [7:0]  uart_data;
  logic        busy;
  logic [15:0] bursts_done;

  int checks = 0;
  int errors = 0;

  buff_uart_tx_arbiter #(
    .width(8), .address_width(4), .tx_address(1), .num_requesters(4), .len_width(4)
  ) dut (
    .clock(clock),
    .resetn(resetn),
    .req(req),
    .burst_len(burst_len),
    .req_data(req_data),
    .grant(grant),
    .word_ack(word_ack),
    .uart_address(uart_address),
    .uart_write_enable(uart_write_enable),
    .uart_data(uart_data),
    .tx_fifo_not_full(tx_fifo_not_full),
    .busy(busy),
    .bursts_done(bursts_done)
  );

  always #5 clock = ~clock;

  // Advance to 1 time unit after the next rising edge; inputs change here,
  // outputs are sampled one unit later.
  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset;
    resetn = 1'b0;
    req = 4'b0000;
    burst_len = 16'h0000;
    req_data = 32'h0;
    tx_fifo_not_full = 1'b1;
    step();
    resetn = 1'b1;
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    req = 4'b1111;
    burst_len = 16'h1111;
    req_data = 32'hFFFF_FFFF;
    tx_fifo_not_full = 1'b1;
    step();
    step();
    #1;
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL reset_grant: got %b expected 0000", grant); end
    checks++; if (word_ack !== 4'b0000) begin errors++; $display("FAIL reset_ack: got %b expected 0000", word_ack); end
    checks++; if (uart_write_enable !== 1'b0) begin errors++; $display("FAIL reset_we: got %b expected 0", uart_write_enable); end
    checks++; if (uart_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", uart_data); end
    checks++; if (uart_address !== 4'h0) begin errors++; $display("FAIL reset_addr: got %h expected 0", uart_address); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (bursts_done !== 16'd0) begin errors++; $display("FAIL reset_bursts: got %0d expected 0", bursts_done); end
  endtask

  task automatic test_single;
    do_reset();
    req = 4'b0001;
    burst_len = 16'h0003;
    req_data = 32'h0000_00A0;
    for (int w = 0; w < 3; w++) begin
      step();
      #1;
      checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL single_grant w%0d: got %b expected 0001", w, grant); end
      checks++; if (uart_write_enable !== 1'b1) begin errors++; $display("FAIL single_we w%0d: got %b expected 1", w, uart_write_enable); end
      checks++; if (uart_data !== 8'hA0 + 8'(w)) begin errors++; $display("FAIL single_data w%0d: got %h expected %h", w, uart_data, 8'hA0 + 8'(w)); end
      checks++; if (word_ack !== 4'b0001) begin errors++; $display("FAIL single_ack w%0d: got %b expected 0001", w, word_ack); end
      checks++; if (uart_address !== 4'h1) begin errors++; $display("FAIL single_addr w%0d: got %h expected 1", w, uart_address); end
      req_data[7:0] = 8'hA1 + 8'(w);
    end
    step();
    req = 4'b0000;
    #1;
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL single_release_grant: got %b expected 0000", grant); end
    checks++; if (uart_write_enable !== 1'b0) begin errors++; $display("FAIL single_release_we: got %b expected 0", uart_write_enable); end
    checks++; if (uart_address !== 4'h0) begin errors++; $display("FAIL single_release_addr: got %h expected 0", uart_address); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_release_busy: got %b expected 1", busy); end
    checks++; if (bursts_done !== 16'd1) begin errors++; $display("FAIL single_bursts: got %0d expected 1", bursts_done); end
    step();
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_round_robin;
    logic [3:0] exp_g;
    logic [7:0] exp_d;
    do_reset();
    req = 4'b1111;
    burst_len = 16'h1111;
    req_data = 32'h1312_1110;
    for (int k = 1; k <= 13; k++) begin
      step();
      #1;
      exp_g = (k % 3 == 1) ? (4'b0001 << ((k / 3) % 4)) : 4'b0000;
      exp_d = (k % 3 == 1) ? (8'h10 + 8'((k / 3) % 4)) : 8'h00;
      checks++; if (grant !== exp_g) begin errors++; $display("FAIL rr_grant c%0d: got %b expected %b", k, grant, exp_g); end
      checks++; if (word_ack !== exp_g) begin errors++; $display("FAIL rr_ack c%0d: got %b expected %b", k, word_ack, exp_g); end
      checks++; if (uart_data !== exp_d) begin errors++; $display("FAIL rr_data c%0d: got %h expected %h", k, uart_data, exp_d); end
    end
    step();
    req = 4'b0000;
    #1;
    checks++; if (bursts_done !== 16'd5) begin errors++; $display("FAIL rr_bursts: got %0d expected 5", bursts_done); end
  endtask

  task automatic test_backpressure;
    int   writes;
    int   nexp;
    logic exp_we;
    writes = 0;
    nexp = 0;
    do_reset();
    req = 4'b0001;
    burst_len = 16'h0004;
    req_data = 32'h0000_00B0;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (k == 1) burst_len = 16'h0001;
      tx_fifo_not_full = !(k >= 3 && k <= 7);
      if (k == 10) req = 4'b0000;
      #1;
      exp_we = (k <= 2) || (k == 8) || (k == 9);
      if (uart_write_enable === 1'b1) writes++;
      checks++; if (uart_write_enable !== exp_we) begin errors++; $display("FAIL bp_we c%0d: got %b expected %b", k, uart_write_enable, exp_we); end
      checks++; if (word_ack !== (exp_we ? 4'b0001 : 4'b0000)) begin errors++; $display("FAIL bp_ack c%0d: got %b expected %b", k, word_ack, exp_we); end
      checks++; if (grant !== ((k <= 9) ? 4'b0001 : 4'b0000)) begin errors++; $display("FAIL bp_grant c%0d: got %b", k, grant); end
      if (k <= 9) begin
        checks++; if (uart_data !== 8'hB0 + 8'(nexp)) begin errors++; $display("FAIL bp_data c%0d: got %h expected %h", k, uart_data, 8'hB0 + 8'(nexp)); end
      end
      if (exp_we) begin
        nexp++;
        req_data[7:0] = 8'hB0 + 8'(nexp);
      end
    end
    checks++; if (writes !== 4) begin errors++; $display("FAIL bp_writes: got %0d expected 4", writes); end
    checks++; if (bursts_done !== 16'd1) begin errors++; $display("FAIL bp_bursts: got %0d expected 1", bursts_done); end
  endtask

  task automatic test_abort;
    do_reset();
    req = 4'b0001;
    burst_len = 16'h0005;
    req_data = 32'h0000_00C0;
    for (int k = 1; k <= 2; k++) begin
      step();
      #1;
      checks++; if (word_ack !== 4'b0001) begin errors++; $display("FAIL abort_ack c%0d: got %b expected 0001", k, word_ack); end
      checks++; if (uart_data !== 8'hBF + 8'(k)) begin errors++; $display("FAIL abort_data c%0d: got %h expected %h", k, uart_data, 8'hBF + 8'(k)); end
      req_data[7:0] = 8'hC0 + 8'(k);
    end
    step();
    req = 4'b0000;
    #1;
    checks++; if (uart_write_enable !== 1'b0) begin errors++; $display("FAIL abort_we: got %b expected 0", uart_write_enable); end
    checks++; if (word_ack !== 4'b0000) begin errors++; $display("FAIL abort_ack_drop: got %b expected 0000", word_ack); end
    step();
    req = 4'b0011;
    burst_len = 16'h0011;
    #1;
    checks++; if (grant !== 4'b0000 || busy !== 1'b1) begin errors++; $display("FAIL abort_release: got grant %b busy %b expected 0000 1", grant, busy); end
    checks++; if (bursts_done !== 16'd0) begin errors++; $display("FAIL abort_bursts: got %0d expected 0", bursts_done); end
    step();
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_idle: got busy %b expected 0", busy); end
    step();
    #1;
    checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL abort_pointer: got %b expected 0010", grant); end
  endtask

  task automatic test_zero_len_reset;
    do_reset();
    req = 4'b0110;
    burst_len = 16'h0200;
    req_data = 32'h00D0_5500;
    step();
    #1;
    checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL zl_grant c1: got %b expected 0100", grant); end
    checks++; if (uart_data !== 8'hD0) begin errors++; $display("FAIL zl_data c1: got %h expected d0", uart_data); end
    req_data[23:16] = 8'hD1;
    step();
    #1;
    checks++; if (grant !== 4'b0100 || uart_data !== 8'hD1) begin errors++; $display("FAIL zl_c2: got grant %b data %h expected 0100 d1", grant, uart_data); end
    step();
    #1;
    checks++; if (grant !== 4'b0000 || bursts_done !== 16'd1) begin errors++; $display("FAIL zl_release: got grant %b bursts %0d expected 0000 1", grant, bursts_done); end
    step();
    req_data[23:16] = 8'hD0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zl_idle: got busy %b expected 0", busy); end
    step();
    #1;
    checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL zl_regrant: got %b expected 0100", grant); end
    resetn = 1'b0;
    step();
    #1;
    checks++; if (grant !== 4'b0000 || word_ack !== 4'b0000 || uart_write_enable !== 1'b0) begin errors++; $display("FAIL rst_mid_ctl: got grant %b ack %b we %b expected 0", grant, word_ack, uart_write_enable); end
    checks++; if (uart_data !== 8'h00 || uart_address !== 4'h0 || busy !== 1'b0) begin errors++; $display("FAIL rst_mid_bus: got data %h addr %h busy %b expected 0", uart_data, uart_address, busy); end
    checks++; if (bursts_done !== 16'd0) begin errors++; $display("FAIL rst_mid_bursts: got %0d expected 0", bursts_done); end
    resetn = 1'b1;
    req = 4'b1010;
    burst_len = 16'h1010;
    step();
    #1;
    checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL rst_pointer: got %b expected 0010", grant); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_abort();
    test_zero_len_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/buff_uart_tx_arbiter.md
BUFF_UART_TX_ARBITER -- requirements
Module: buff_uart_tx_arbiter

Interface
REQ-001 Parameter: width, 8, data word width in bits; matches the buffered UART word width.
REQ-002 Parameter: address_width, 4, width of the UART bus address.
REQ-003 Parameter: tx_address, 1, address driven on uart_address during transmit writes.
REQ-004 Parameter: num_requesters, 4, number of requesters (2..8).
REQ-005 Parameter: len_width, 4, width of each burst length field; max burst 2**len_width-1 words.
REQ-006 Port: clock  input  1  single clock; all logic on posedge.
REQ-007 Port: resetn  input  1  reset, synchronous, active-low.
REQ-008 Port: req  input  num_requesters  per-requester burst request, level.
REQ-009 Port: burst_len  input  num_requesters*len_width  per-requester word count; slice i at [i*len_width +: len_width].
REQ-010 Port: req_data  input  num_requesters*width  per-requester current word; slice i at [i*width +: width].
REQ-011 Port: grant  output  num_requesters  one-hot (or zero) ownership of the UART transmit path.
REQ-012 Port: word_ack  output  num_requesters  one-cycle pulse; granted requester presents its next word in the following cycle.
REQ-013 Port: uart_address  output  address_width  UART bus address.
REQ-014 Port: uart_write_enable  output  1  UART transmit FIFO write strobe.
REQ-015 Port: uart_data  output  width  word to the UART transmit FIFO.
REQ-016 Port: tx_fifo_not_full  input  1  UART transmit FIFO can accept a word.
REQ-017 Port: busy  output  1  high in any state other than IDLE.
REQ-018 Port: bursts_done  output  16  count of completed (non-aborted) bursts, wraps at 65535 -> 0.

Function
REQ-019 FSM states: IDLE, SEND, RELEASE; state, grant, remaining counter and priority pointer are registered.
REQ-020 Eligible requester i: req[i]=1 and burst_len slice i != 0; zero-length requests are ignored.
REQ-021 IDLE: if any requester is eligible, register grant to the first eligible index scanning upward (with wrap) from the priority pointer, latch its burst_len into remaining, go to SEND next cycle; otherwise stay in IDLE.
REQ-022 SEND: uart_write_enable = tx_fifo_not_full (combinational); uart_data = granted requester's req_data; word_ack[granted] = uart_write_enable.
REQ-023 Word accepted when uart_write_enable=1; remaining decrements by 1 per accepted word.
REQ-024 SEND with remaining=1 and a word accepted: increment bursts_done, go to RELEASE.
REQ-025 SEND with req[granted]=0: abort; no write that cycle; bursts_done unchanged; go to RELEASE.
REQ-026 SEND with tx_fifo_not_full=0: stall with no write and no ack; counter and grant hold; no timeout.
REQ-027 RELEASE: grant=0, no write; priority pointer = (granted index + 1) mod num_requesters; go to IDLE next cycle.
REQ-028 Latency: req rises in cycle N in IDLE -> grant and first possible write in cycle N+1; minimum gap between bursts is 2 cycles (RELEASE, IDLE).
REQ-029 uart_address = tx_address while in SEND, 0 otherwise; uart_write_enable, uart_data and word_ack are 0 outside SEND.
REQ-030 Changes to burst_len after grant have no effect on the current burst.
REQ-031 At most one grant bit is high; at most one word_ack bit is high, and only the granted one.

Reset
REQ-032 resetn=0 at a posedge: state=IDLE, grant=0, remaining=0, priority pointer=0, bursts_done=0; word_ack, uart_write_enable, uart_data, uart_address and busy are 0 in the following cycle.
REQ-033 Reset mid-burst: the burst is dropped without completion and no further writes occur; after release, arbitration restarts from index 0.

Verification
REQ-034 Single: req[0]=1, burst_len0=3, FIFO never full -> 3 consecutive writes of req_data0 values, grant0 high for 3 cycles, bursts_done=1.
REQ-035 Round-robin: req[0..3] all held, burst_len=1 each -> grant order 0,1,2,3,0; each grant separated by exactly 2 idle-grant cycles.
REQ-036 Backpressure: burst_len=4, tx_fifo_not_full low for 5 cycles after the 2nd write -> exactly 4 writes total, no ack during the stall, grant held.
REQ-037 Abort: burst_len=5, req drops after 2 acks -> 2 writes, RELEASE the next cycle, bursts_done unchanged, pointer advances past the aborted index.
REQ-038 Zero length / reset: req[1]=1 with len 0 and req[2]=1 with len 2 -> grant2 only; resetn=0 mid-burst -> all outputs 0 next cycle and bursts_done=0.
